// File: rtl/mul_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
//
// Shared types and widths for the serial-multiplier operand sequencer.
//   state_t : sequencer FSM states, in the order a job walks through them
//   OPW     : width of one operand byte and of the multiplier's in/out buses
//   PRODW   : width of the reassembled signed product {A, Q}
// ---------------------------------------------------------------------------
package mul_seq_pkg;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

  // A job goes IDLE -> LOAD_M -> LOAD_Q -> RUN -> CAP_HI -> CAP_LO -> OUT,
  // except that a RUN which never sees mul_done jumps straight to OUT.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    RUN    = 3'd3,
    CAP_HI = 3'd4,
    CAP_LO = 3'd5,
    OUT    = 3'd6
  } state_t;

endpackage

// File: rtl/mul_operand_sequencer_hold_counter.sv
// ---------------------------------------------------------------------------
// hold_counter
//
// Small up-counter used to time how long the sequencer stays in a state.
// The count is compared against a caller-supplied limit; tc is high while the
// count equals that limit, so a state that must last N cycles passes N-1.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset, clears the count
//   clr    in   synchronous clear, wins over en
//   en     in   count enable
//   limit  in   WIDTH-bit terminal value
//   tc     out  count == limit
// ---------------------------------------------------------------------------
module hold_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Clear has priority so the owner can restart timing on the same edge it
  // changes state, regardless of whether counting is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mul_operand_sequencer
//
// Front/back-end stage for the 8-bit serial signed multiplier. Takes one
// operand pair on a valid/ready handshake, feeds the multiplier's shared
// inbus (M first, then Q) while holding its enable, waits for mul_done,
// collects the two result bytes from the outbus (A high, then Q low) and
// offers the 16-bit product on a valid/ready handshake. If the multiplier
// never finishes, an error result (out_err=1, product 0) is offered instead.
//
// Parameters:
//   M_HOLD  : cycles M is driven on mul_inbus (1..15)
//   Q_HOLD  : cycles Q is driven on mul_inbus (1..15)
//   HI_DLY  : cycles after mul_done before the high byte is sampled (0..7)
//   LO_DLY  : cycles after the high-byte sample before the low byte (1..7)
//   TIMEOUT : RUN cycles allowed before giving up on mul_done (>=16)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operand handshake, in_mcand/in_mplier operands
//   mul_enable, mul_inbus      drive to the multiplier
//   mul_done, mul_outbus       status and result bytes from the multiplier
//   out_valid/out_ready        product handshake, out_product/out_err result
//   busy                       high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int M_HOLD  = 1,
  parameter int Q_HOLD  = 1,
  parameter int HI_DLY  = 0,
  parameter int LO_DLY  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_mcand,
  input  logic [OPW-1:0]   in_mplier,
  output logic             mul_enable,
  output logic [OPW-1:0]   mul_inbus,
  input  logic             mul_done,
  input  logic [OPW-1:0]   mul_outbus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_product,
  output logic             out_err,
  output logic             busy
);

  localparam int HOLD_W = 4;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // The timeout counter stops on this value, so it can never wrap.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

  state_t state;
  state_t state_next;

  logic [OPW-1:0]    m_reg;
  logic [OPW-1:0]    q_reg;

  logic              hold_clr;
  logic              hold_en;
  logic              hold_tc;
  logic [HOLD_W-1:0] hold_limit;

  logic              to_clr;
  logic              to_en;
  logic              to_tc;

  logic              accept;
  logic              timeout_hit;
  logic              hi_sample;
  logic              lo_sample;
  logic              release_out;

  // State register. Reset drops any job in flight back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore outputs. mul_done is only looked at in RUN, so an
  // early pulse while operands are still being loaded is simply ignored.
  // When done and the timeout land in the same cycle, done wins.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mul_enable = 1'b0;
    mul_inbus  = '0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = LOAD_M;
        end
      end
      LOAD_M: begin
        mul_enable = 1'b1;
        mul_inbus  = m_reg;
        if (hold_tc) begin
          state_next = LOAD_Q;
        end
      end
      LOAD_Q: begin
        mul_enable = 1'b1;
        mul_inbus  = q_reg;
        if (hold_tc) begin
          state_next = RUN;
        end
      end
      RUN: begin
        mul_enable = 1'b1;
        if (mul_done) begin
          state_next = CAP_HI;
        end else if (to_tc) begin
          state_next = OUT;
        end
      end
      CAP_HI: begin
        if (hold_tc) begin
          state_next = CAP_LO;
        end
      end
      CAP_LO: begin
        if (hold_tc) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-state hold limit. LOAD and CAP_LO states last exactly N cycles so
  // they stop at N-1; CAP_HI waits HI_DLY cycles and then spends one more
  // cycle sampling, so it stops at HI_DLY itself.
  always_comb begin
    hold_limit = '0;
    case (state)
      LOAD_M:  hold_limit = HOLD_W'(M_HOLD - 1);
      LOAD_Q:  hold_limit = HOLD_W'(Q_HOLD - 1);
      CAP_HI:  hold_limit = HOLD_W'(HI_DLY);
      CAP_LO:  hold_limit = HOLD_W'(LO_DLY - 1);
      default: hold_limit = '0;
    endcase
  end

  // The hold counter restarts on every state change; it only runs in the
  // states whose duration it times.
  assign hold_clr = (state_next != state);
  assign hold_en  = (state == LOAD_M) || (state == LOAD_Q) ||
                    (state == CAP_HI) || (state == CAP_LO);

  // The timeout counter sits at zero outside RUN, which makes it zero on
  // every RUN entry, and it freezes once it hits the limit.
  assign to_clr = (state != RUN);
  assign to_en  = (state == RUN) && !to_tc;

  hold_counter #(
    .WIDTH (HOLD_W)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .en    (hold_en),
    .limit (hold_limit),
    .tc    (hold_tc)
  );

  hold_counter #(
    .WIDTH (TO_W)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .en    (to_en),
    .limit (TO_LIMIT),
    .tc    (to_tc)
  );

  assign accept      = (state == IDLE) && in_valid;
  assign timeout_hit = (state == RUN) && !mul_done && to_tc;
  assign hi_sample   = (state == CAP_HI) && hold_tc;
  assign lo_sample   = (state == CAP_LO) && hold_tc;
  assign release_out = (state == OUT) && out_ready;

  // Operand latch. Operands are captured only on acceptance, so anything
  // presented while busy never reaches the multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg <= '0;
      q_reg <= '0;
    end else if (accept) begin
      m_reg <= in_mcand;
      q_reg <= in_mplier;
    end
  end

  // Result register. The bytes are concatenated as delivered; a timeout
  // forces a zero product with the error flag, and the flag drops together
  // with out_valid when the consumer takes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_product <= '0;
      out_err     <= 1'b0;
    end else begin
      if (timeout_hit) begin
        out_product <= '0;
        out_err     <= 1'b1;
      end
      if (hi_sample) begin
        out_product[PRODW-1:OPW] <= mul_outbus;
      end
      if (lo_sample) begin
        out_product[OPW-1:0] <= mul_outbus;
      end
      if (release_out) begin
        out_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_operand_sequencer
//
// Self-checking bench. Each job is described by a record (operands, how many
// RUN cycles until the bench's multiplier answers, consumer stall, expected
// product). A reference timeline derived from the hold/delay parameters says
// what every DUT output must be in every cycle after acceptance; the bench
// also plays the multiplier, answering with the signed product of the bytes
// it saw on mul_inbus and putting each result byte on mul_outbus only in the
// single cycle in which it must be sampled.
// ---------------------------------------------------------------------------
module tb_mul_operand_sequencer;

  localparam int M_HOLD  = 1;
  localparam int Q_HOLD  = 1;
  localparam int HI_DLY  = 0;
  localparam int LO_DLY  = 1;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_mcand;
  logic [7:0]  in_mplier;
  logic        mul_enable;
  logic [7:0]  mul_inbus;
  logic        mul_done;
  logic [7:0]  mul_outbus;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_err;
  logic        busy;

  int checks;
  int failures;

  typedef struct packed {
    logic        in_ready;
    logic        busy;
    logic        mul_enable;
    logic [7:0]  mul_inbus;
    logic        out_valid;
    logic        out_err;
    logic [15:0] out_product;
  } obs_t;

  // d = RUN cycles until mul_done (0 = never), w = out_ready stall cycles,
  // spur = mul_done pulses during loading, hold = in_valid held high.
  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    int          d;
    int          w;
    bit          spur;
    bit          hold;
    logic [15:0] exp_product;
    bit          exp_err;
  } job_t;

  job_t jobs[$];

  mul_operand_sequencer #(
    .M_HOLD  (M_HOLD),
    .Q_HOLD  (Q_HOLD),
    .HI_DLY  (HI_DLY),
    .LO_DLY  (LO_DLY),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mcand    (in_mcand),
    .in_mplier   (in_mplier),
    .mul_enable  (mul_enable),
    .mul_inbus   (mul_inbus),
    .mul_done    (mul_done),
    .mul_outbus  (mul_outbus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_err     (out_err),
    .busy        (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never finishes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 16'(ia * ib);
  endfunction

  // Drive every DUT input for the coming clock edge.
  task automatic applyStimulus(input logic v, input logic [7:0] m, input logic [7:0] q,
                               input logic done, input logic [7:0] obus, input logic rdy);
    in_valid   = v;
    in_mcand   = m;
    in_mplier  = q;
    mul_done   = done;
    mul_outbus = obus;
    out_ready  = rdy;
  endtask

  // Compare all outputs in one go; the product is ignored while no product
  // is expected unless 'full' asks for it.
  task automatic checkOutput(input string tag, input int n, input obs_t exp_in, input bit full);
    obs_t act;
    obs_t e;
    e   = exp_in;
    act = {in_ready, busy, mul_enable, mul_inbus, out_valid, out_err, out_product};
    if (!full && !e.out_valid) begin
      act.out_product = '0;
      e.out_product   = '0;
    end
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual rdy=%b busy=%b en=%b inbus=%h vld=%b err=%b prod=%h required rdy=%b busy=%b en=%b inbus=%h vld=%b err=%b prod=%h",
               tag, n, act.in_ready, act.busy, act.mul_enable, act.mul_inbus, act.out_valid,
               act.out_err, act.out_product, e.in_ready, e.busy, e.mul_enable, e.mul_inbus,
               e.out_valid, e.out_err, e.out_product);
    end
  endtask

  // Run one job from its acceptance cycle (n=0) to the cycle the product is
  // taken, checking every cycle against the reference timeline.
  task automatic runJob(input job_t j, input int id);
    int          t_run;
    int          t_done;
    int          n_hi;
    int          n_lo;
    int          n_out;
    int          n_acc;
    logic [7:0]  cap_m;
    logic [7:0]  cap_q;
    logic [15:0] mprod;
    obs_t        e;
    logic        v_n;
    logic        done_n;
    logic        rdy_n;
    logic [7:0]  m_n;
    logic [7:0]  q_n;
    logic [7:0]  obus_n;
    t_run  = (j.d == 0) ? TIMEOUT : j.d;
    t_done = M_HOLD + Q_HOLD + t_run;
    n_hi   = t_done + HI_DLY + 1;
    n_lo   = n_hi + LO_DLY;
    n_out  = (j.d == 0) ? t_done + 1 : n_lo + 1;
    n_acc  = n_out + j.w;
    cap_m  = '0;
    cap_q  = '0;
    mprod  = '0;
    for (int n = 0; n <= n_acc; n++) begin
      @(negedge clk);
      e.in_ready   = (n == 0);
      e.busy       = (n != 0);
      e.mul_enable = (n >= 1) && (n <= t_done);
      if (n >= 1 && n <= M_HOLD) begin
        e.mul_inbus = j.m;
      end else if (n > M_HOLD && n <= M_HOLD + Q_HOLD) begin
        e.mul_inbus = j.q;
      end else begin
        e.mul_inbus = '0;
      end
      e.out_valid   = (n >= n_out);
      e.out_err     = e.out_valid && j.exp_err;
      e.out_product = e.out_valid ? j.exp_product : '0;
      checkOutput($sformatf("job%0d", id), n, e, 1'b0);

      if (n == 1) begin
        cap_m = mul_inbus;
      end
      if (n == M_HOLD + 1) begin
        cap_q = mul_inbus;
        mprod = refProduct(cap_m, cap_q);
      end

      if (n == 0) begin
        v_n = 1'b1;
        m_n = j.m;
        q_n = j.q;
      end else begin
        v_n = (n == n_acc) ? j.hold : (j.hold ? 1'b1 : 1'($urandom_range(0, 1)));
        m_n = 8'($urandom);
        q_n = 8'($urandom);
      end
      done_n = ((j.d != 0) && (n == t_done)) || (j.spur && (n == 1 || n == M_HOLD + 1));
      if (j.d != 0 && n == n_hi) begin
        obus_n = mprod[15:8];
      end else if (j.d != 0 && n == n_lo) begin
        obus_n = mprod[7:0];
      end else begin
        obus_n = 8'($urandom);
      end
      rdy_n = (n < n_out) ? 1'($urandom_range(0, 1)) : (n == n_acc);
      applyStimulus(v_n, m_n, q_n, done_n, obus_n, rdy_n);
    end
  endtask

  function automatic job_t mkJob(input logic [7:0] m, input logic [7:0] q, input int d,
                                 input int w, input bit spur, input bit hold,
                                 input logic [15:0] p, input bit err);
    job_t j;
    j.m = m; j.q = q; j.d = d; j.w = w; j.spur = spur; j.hold = hold;
    j.exp_product = p; j.exp_err = err;
    return j;
  endfunction

  initial begin
    obs_t reset_exp;
    obs_t run_exp;
    job_t rj;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b1, 8'h77, 8'h66, 1'b1, 8'h5A, 1'b1);

    // Vector table: basic, corners, backpressure, timeout and recovery,
    // done on the very last RUN cycle, spurious done, back-to-back.
    jobs.push_back(mkJob(8'h05, 8'hFD, 3,       0,  0, 0, 16'hFFF1, 0));
    jobs.push_back(mkJob(8'h80, 8'h80, 5,       0,  0, 0, 16'h4000, 0));
    jobs.push_back(mkJob(8'h80, 8'h7F, 2,       0,  0, 0, 16'hC080, 0));
    jobs.push_back(mkJob(8'h3A, 8'hC5, 4,       10, 0, 0, 16'hF2A2, 0));
    jobs.push_back(mkJob(8'h12, 8'h34, 0,       0,  0, 0, 16'h0000, 1));
    jobs.push_back(mkJob(8'h12, 8'h34, 6,       0,  0, 0, 16'h03A8, 0));
    jobs.push_back(mkJob(8'h7F, 8'h7F, TIMEOUT, 0,  0, 0, 16'h3F01, 0));
    jobs.push_back(mkJob(8'hFF, 8'h01, 1,       0,  1, 0, 16'hFFFF, 0));
    jobs.push_back(mkJob(8'h02, 8'h03, 1,       0,  0, 1, 16'h0006, 0));
    jobs.push_back(mkJob(8'hFE, 8'h03, 7,       0,  0, 1, 16'hFFFA, 0));
    jobs.push_back(mkJob(8'h00, 8'h55, 2,       0,  0, 1, 16'h0000, 0));
    jobs.push_back(mkJob(8'h7F, 8'h80, 1,       0,  0, 1, 16'hC080, 0));

    reset_exp = '{in_ready: 1'b1, busy: 1'b0, mul_enable: 1'b0, mul_inbus: 8'h00,
                  out_valid: 1'b0, out_err: 1'b0, out_product: 16'h0000};
    run_exp   = '{in_ready: 1'b0, busy: 1'b1, mul_enable: 1'b1, mul_inbus: 8'h00,
                  out_valid: 1'b0, out_err: 1'b0, out_product: 16'h0000};

    // Power-on reset with busy-looking inputs: nothing may be accepted.
    repeat (3) @(negedge clk);
    checkOutput("por", 0, reset_exp, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    foreach (jobs[i]) begin
      runJob(jobs[i], i);
    end

    // Reset in the middle of RUN, then a late mul_done with no job in flight.
    @(negedge clk);
    checkOutput("rst_seq", 0, reset_exp, 1'b0);
    applyStimulus(1'b1, 8'h21, 8'h43, 1'b0, 8'h00, 1'b1);
    for (int n = 1; n <= M_HOLD + Q_HOLD + 3; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'($urandom), 1'b1);
    end
    checkOutput("rst_in_run", M_HOLD + Q_HOLD + 3, run_exp, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_clear", 0, reset_exp, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b1);
      @(negedge clk);
      checkOutput("rst_late_done", n, reset_exp, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomized jobs checked against the signed-product reference.
    for (int i = 0; i < 16; i++) begin
      rj.m    = 8'($urandom);
      rj.q    = 8'($urandom);
      rj.d    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      rj.w    = int'($urandom_range(0, 3));
      rj.spur = 1'($urandom_range(0, 1));
      rj.hold = 1'($urandom_range(0, 1));
      rj.exp_err     = (rj.d == 0);
      rj.exp_product = (rj.d == 0) ? 16'h0000 : refProduct(rj.m, rj.q);
      runJob(rj, 100 + i);
    end

    @(negedge clk);
    checkOutput("final_idle", 0, reset_exp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
